// File: rtl/cpu_irq_pkg.sv
// Shared definitions for the 6502 interrupt/vector sequencer: vectors, P-bit
// positions, stack page and the FSM/action encodings.
package cpu_irq_pkg;

    localparam logic [15:0] DEF_NMI_VEC = 16'hFFFA;
    localparam logic [15:0] DEF_RST_VEC = 16'hFFFC;
    localparam logic [15:0] DEF_BRK_VEC = 16'hFFFE;

    localparam logic [7:0] STACK_PAGE = 8'h01;

    localparam int P_C = 0;
    localparam int P_Z = 1;
    localparam int P_I = 2;
    localparam int P_D = 3;
    localparam int P_B = 4;
    localparam int P_U = 5;
    localparam int P_V = 6;
    localparam int P_N = 7;

    localparam logic [7:0] MASK_I = 8'(1 << P_I);
    localparam logic [7:0] MASK_B = 8'(1 << P_B);
    localparam logic [7:0] MASK_U = 8'(1 << P_U);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PUSH_H,
        ST_PUSH_L,
        ST_PUSH_P,
        ST_PULL_P,
        ST_PULL_L,
        ST_PULL_H,
        ST_VEC_L,
        ST_VEC_H,
        ST_WAIT,
        ST_FINISH
    } irq_state_t;

    typedef enum logic [2:0] {
        ACT_PASS,
        ACT_RST,
        ACT_BRK,
        ACT_RTI,
        ACT_NMI
    } irq_act_t;

    function automatic logic [15:0] stack_addr(input logic [7:0] sp);
        return {STACK_PAGE, sp};
    endfunction

endpackage

// File: rtl/cpu_interrupt_handler.sv
// Runs the 6502 reset/NMI/BRK/RTI bus sequences for the execution FSM and
// returns the resulting PC, P and SP (or the inputs unchanged when idle-passing).
//
// state     | meaning
// IDLE      | waiting for interrupt_start; results held
// PUSH_H    | write PCH to stack
// PUSH_L    | write PCL to stack
// PUSH_P    | write status to stack
// PULL_P    | issue read of P from stack
// PULL_L    | issue read of PCL from stack
// PULL_H    | issue read of PCH from stack
// VEC_L     | issue read of vector low byte
// VEC_H     | issue read of vector high byte
// WAIT      | two-cycle read latency, then capture byte
// FINISH    | publish results, done=1
module cpu_interrupt_handler
    import cpu_irq_pkg::*;
#(
    parameter logic [15:0] NMI_VEC = DEF_NMI_VEC,
    parameter logic [15:0] RST_VEC = DEF_RST_VEC,
    parameter logic [15:0] BRK_VEC = DEF_BRK_VEC
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] interrupt_addr,
    input  logic [7:0]  mem_data_in,
    output logic [7:0]  interrupt_data_out,
    output logic        interrupt_write_en,
    input  logic        is_break,
    input  logic [7:0]  ppu_status,
    input  logic        soft_reset,
    input  logic        is_rti,
    input  logic        interrupt_start,
    output logic        interrupt_done,
    output logic        interrupt_busy,
    input  logic [15:0] pc_next,
    input  logic [7:0]  ie_status,
    input  logic [7:0]  stack_ptr,
    output logic [15:0] interrupt_pc_out,
    output logic [7:0]  interrupt_status_out,
    output logic [7:0]  interrupt_stack_out,
    output logic        interrupt_disable,
    input  logic        halt
);

    irq_state_t state, state_n;
    irq_state_t rd_src, rd_src_n;
    irq_act_t   act, act_n;
    logic       lat, lat_n;
    logic [15:0] pc_r, pc_n;
    logic [7:0]  p_r, p_n;
    logic [7:0]  sp_r, sp_n;
    logic [7:0]  pcl_r, pcl_n;
    logic [7:0]  pch_r, pch_n;
    logic [7:0]  pp_r, pp_n;
    logic        nmi_pending, nmi_pending_n;
    logic        vblank_q;
    logic        rst_pending, rst_pending_n;
    logic        nmi_rise;

    logic [15:0] addr_n;
    logic [7:0]  data_n;
    logic        we_n;
    logic        done_n;
    logic        busy_n;
    logic [15:0] pc_out_n;
    logic [7:0]  status_out_n;
    logic [7:0]  stack_out_n;
    logic [15:0] vec_base;

    logic unused_ppu_bits;
    assign unused_ppu_bits = ^ppu_status[6:0];

    assign nmi_rise = ppu_status[7] & ~vblank_q;
    assign interrupt_disable = interrupt_status_out[P_I];

    always_comb begin
        vec_base = BRK_VEC;
        if (act == ACT_NMI) vec_base = NMI_VEC;
        else if (act == ACT_RST) vec_base = RST_VEC;
    end

    always_comb begin
        state_n       = state;
        rd_src_n      = rd_src;
        act_n         = act;
        lat_n         = lat;
        pc_n          = pc_r;
        p_n           = p_r;
        sp_n          = sp_r;
        pcl_n         = pcl_r;
        pch_n         = pch_r;
        pp_n          = pp_r;
        addr_n        = interrupt_addr;
        data_n        = interrupt_data_out;
        we_n          = 1'b0;
        done_n        = interrupt_done;
        busy_n        = interrupt_busy;
        pc_out_n      = interrupt_pc_out;
        status_out_n  = interrupt_status_out;
        stack_out_n   = interrupt_stack_out;
        nmi_pending_n = nmi_pending | nmi_rise;
        rst_pending_n = rst_pending | soft_reset;

        case (state)
            ST_IDLE: begin
                if (interrupt_start) begin
                    done_n = 1'b0;
                    busy_n = 1'b1;
                    pc_n   = pc_next;
                    p_n    = ie_status;
                    sp_n   = stack_ptr;
                    if (rst_pending) begin
                        act_n         = ACT_RST;
                        rst_pending_n = soft_reset;
                        sp_n          = stack_ptr - 8'd3;
                        state_n       = ST_VEC_L;
                    end else if (is_break) begin
                        act_n   = ACT_BRK;
                        state_n = ST_PUSH_H;
                    end else if (is_rti) begin
                        act_n   = ACT_RTI;
                        state_n = ST_PULL_P;
                    end else if (nmi_pending) begin
                        // a fresh edge on this same cycle stays pending
                        act_n         = ACT_NMI;
                        nmi_pending_n = nmi_rise;
                        state_n       = ST_PUSH_H;
                    end else begin
                        act_n   = ACT_PASS;
                        state_n = ST_FINISH;
                    end
                end
            end
            ST_PUSH_H: begin
                addr_n  = stack_addr(sp_r);
                data_n  = pc_r[15:8];
                we_n    = 1'b1;
                sp_n    = sp_r - 8'd1;
                state_n = ST_PUSH_L;
            end
            ST_PUSH_L: begin
                addr_n  = stack_addr(sp_r);
                data_n  = pc_r[7:0];
                we_n    = 1'b1;
                sp_n    = sp_r - 8'd1;
                state_n = ST_PUSH_P;
            end
            ST_PUSH_P: begin
                addr_n  = stack_addr(sp_r);
                data_n  = (act == ACT_NMI) ? ((p_r & ~MASK_B) | MASK_U) : (p_r | MASK_B | MASK_U);
                we_n    = 1'b1;
                sp_n    = sp_r - 8'd1;
                state_n = ST_VEC_L;
            end
            ST_PULL_P, ST_PULL_L, ST_PULL_H: begin
                sp_n     = sp_r + 8'd1;
                addr_n   = stack_addr(sp_r + 8'd1);
                rd_src_n = state;
                lat_n    = 1'b0;
                state_n  = ST_WAIT;
            end
            ST_VEC_L: begin
                addr_n   = vec_base;
                rd_src_n = state;
                lat_n    = 1'b0;
                state_n  = ST_WAIT;
            end
            ST_VEC_H: begin
                addr_n   = vec_base + 16'd1;
                rd_src_n = state;
                lat_n    = 1'b0;
                state_n  = ST_WAIT;
            end
            ST_WAIT: begin
                if (!lat) begin
                    lat_n = 1'b1;
                end else begin
                    case (rd_src)
                        ST_PULL_P: begin pp_n  = mem_data_in; state_n = ST_PULL_L; end
                        ST_PULL_L: begin pcl_n = mem_data_in; state_n = ST_PULL_H; end
                        ST_PULL_H: begin pch_n = mem_data_in; state_n = ST_FINISH; end
                        ST_VEC_L:  begin pcl_n = mem_data_in; state_n = ST_VEC_H;  end
                        ST_VEC_H:  begin pch_n = mem_data_in; state_n = ST_FINISH; end
                        default:   state_n = ST_FINISH;
                    endcase
                end
            end
            ST_FINISH: begin
                done_n      = 1'b1;
                busy_n      = 1'b0;
                stack_out_n = sp_r;
                state_n     = ST_IDLE;
                case (act)
                    ACT_PASS: begin
                        pc_out_n     = pc_r;
                        status_out_n = p_r;
                    end
                    ACT_RTI: begin
                        pc_out_n     = {pch_r, pcl_r};
                        status_out_n = (pp_r & ~MASK_B) | MASK_U;
                    end
                    default: begin
                        pc_out_n     = {pch_r, pcl_r};
                        status_out_n = p_r | MASK_I;
                    end
                endcase
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                <= ST_IDLE;
            rd_src               <= ST_IDLE;
            act                  <= ACT_PASS;
            lat                  <= 1'b0;
            pc_r                 <= '0;
            p_r                  <= '0;
            sp_r                 <= '0;
            pcl_r                <= '0;
            pch_r                <= '0;
            pp_r                 <= '0;
            nmi_pending          <= 1'b0;
            vblank_q             <= 1'b0;
            rst_pending          <= 1'b0;
            interrupt_addr       <= '0;
            interrupt_data_out   <= '0;
            interrupt_write_en   <= 1'b0;
            interrupt_done       <= 1'b0;
            interrupt_busy       <= 1'b0;
            interrupt_pc_out     <= '0;
            interrupt_status_out <= '0;
            interrupt_stack_out  <= 8'hFF;
        end else if (!halt) begin
            state                <= state_n;
            rd_src               <= rd_src_n;
            act                  <= act_n;
            lat                  <= lat_n;
            pc_r                 <= pc_n;
            p_r                  <= p_n;
            sp_r                 <= sp_n;
            pcl_r                <= pcl_n;
            pch_r                <= pch_n;
            pp_r                 <= pp_n;
            nmi_pending          <= nmi_pending_n;
            vblank_q             <= ppu_status[7];
            rst_pending          <= rst_pending_n;
            interrupt_addr       <= addr_n;
            interrupt_data_out   <= data_n;
            interrupt_write_en   <= we_n;
            interrupt_done       <= done_n;
            interrupt_busy       <= busy_n;
            interrupt_pc_out     <= pc_out_n;
            interrupt_status_out <= status_out_n;
            interrupt_stack_out  <= stack_out_n;
        end
    end

endmodule

// File: tb/tb_cpu_interrupt_handler.sv
// Bench for cpu_interrupt_handler: directed vector table, randomized ops against
// a behavioural model, plus halt and mid-sequence reset sequences.
module tb_cpu_interrupt_handler;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] interrupt_addr;
    logic [7:0]  mem_data_in;
    logic [7:0]  interrupt_data_out;
    logic        interrupt_write_en;
    logic        is_break;
    logic [7:0]  ppu_status;
    logic        soft_reset;
    logic        is_rti;
    logic        interrupt_start;
    logic        interrupt_done;
    logic        interrupt_busy;
    logic [15:0] pc_next;
    logic [7:0]  ie_status;
    logic [7:0]  stack_ptr;
    logic [15:0] interrupt_pc_out;
    logic [7:0]  interrupt_status_out;
    logic [7:0]  interrupt_stack_out;
    logic        interrupt_disable;
    logic        halt;

    always #5 clk = ~clk;

    cpu_interrupt_handler dut (
        .clk                  (clk),
        .rst                  (rst),
        .interrupt_addr       (interrupt_addr),
        .mem_data_in          (mem_data_in),
        .interrupt_data_out   (interrupt_data_out),
        .interrupt_write_en   (interrupt_write_en),
        .is_break             (is_break),
        .ppu_status           (ppu_status),
        .soft_reset           (soft_reset),
        .is_rti               (is_rti),
        .interrupt_start      (interrupt_start),
        .interrupt_done       (interrupt_done),
        .interrupt_busy       (interrupt_busy),
        .pc_next              (pc_next),
        .ie_status            (ie_status),
        .stack_ptr            (stack_ptr),
        .interrupt_pc_out     (interrupt_pc_out),
        .interrupt_status_out (interrupt_status_out),
        .interrupt_stack_out  (interrupt_stack_out),
        .interrupt_disable    (interrupt_disable),
        .halt                 (halt)
    );

    // synchronous-read RAM: data for the address seen at one edge appears after the next
    logic [7:0]  mem [0:65535];
    logic [7:0]  mem_q;
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    assign mem_data_in = mem_q;

    always @(posedge clk) begin
        mem_q <= mem[interrupt_addr];
        if (rst && !halt && interrupt_write_en) begin
            mem[interrupt_addr] <= interrupt_data_out;
            wr_a.push_back(interrupt_addr);
            wr_d.push_back(interrupt_data_out);
        end
    end

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act_v, input logic [31:0] exp_v);
        tests++;
        if (act_v !== exp_v) begin
            fails++;
            $display("FAIL %s: actual %0h required %0h", nm, act_v, exp_v);
        end
    endtask

    // behavioural model: pending flags plus expected results of the next start
    bit          m_nmi = 1'b0;
    bit          m_rst = 1'b0;
    logic [15:0] e_pc;
    logic [7:0]  e_p;
    logic [7:0]  e_sp;
    int          e_nwr;
    logic [15:0] e_wa[3];
    logic [7:0]  e_wd[3];

    task automatic model(input logic [15:0] pc, input logic [7:0] p, input logic [7:0] sp,
                         input bit brk, input bit rti);
        int s;
        int kind;
        int vec;
        s = int'(sp);
        e_nwr = 0; e_pc = pc; e_p = p; e_sp = sp;
        if (m_rst)      kind = 1;
        else if (brk)   kind = 2;
        else if (rti)   kind = 3;
        else if (m_nmi) kind = 4;
        else            kind = 0;
        if (kind == 1) m_rst = 1'b0;
        if (kind == 4) m_nmi = 1'b0;
        if (kind == 2 || kind == 4) begin
            e_nwr = 3;
            for (int i = 0; i < 3; i++) e_wa[i] = 16'(256 + (s - i + 256) % 256);
            e_wd[0] = pc[15:8];
            e_wd[1] = pc[7:0];
            e_wd[2] = (kind == 2) ? (p | 8'h30) : ((p & 8'hEF) | 8'h20);
        end
        vec = (kind == 1) ? 16'hFFFC : (kind == 4) ? 16'hFFFA : 16'hFFFE;
        if (kind == 1 || kind == 2 || kind == 4) begin
            e_pc = {mem[vec + 1], mem[vec]};
            e_p  = p | 8'h04;
            e_sp = 8'((s + 253) % 256);
        end
        if (kind == 3) begin
            e_p  = (mem[256 + (s + 1) % 256] & 8'hEF) | 8'h20;
            e_pc = {mem[256 + (s + 3) % 256], mem[256 + (s + 2) % 256]};
            e_sp = 8'((s + 3) % 256);
        end
    endtask

    task automatic run_op(input string nm, input logic [15:0] pc, input logic [7:0] p,
                          input logic [7:0] sp, input bit brk, input bit rti,
                          input int halt_at, input int halt_len, output int lat);
        int base;
        int n;
        model(pc, p, sp, brk, rti);
        @(negedge clk);
        chk({nm, ".busy_before_start"}, 32'(interrupt_busy), 32'd0);
        base = wr_a.size();
        pc_next = pc; ie_status = p; stack_ptr = sp;
        is_break = brk; is_rti = rti; interrupt_start = 1'b1;
        @(negedge clk);
        interrupt_start = 1'b0; is_break = 1'b0; is_rti = 1'b0;
        chk({nm, ".busy_after_start"}, 32'(interrupt_busy), 32'd1);
        lat = 0;
        while (!interrupt_done && lat < 200) begin
            if (lat == halt_at) halt = 1'b1;
            if (lat == halt_at + halt_len) halt = 1'b0;
            @(negedge clk);
            lat++;
        end
        halt = 1'b0;
        chk({nm, ".done"}, 32'(interrupt_done), 32'd1);
        chk({nm, ".pc"}, 32'(interrupt_pc_out), 32'(e_pc));
        chk({nm, ".status"}, 32'(interrupt_status_out), 32'(e_p));
        chk({nm, ".stack"}, 32'(interrupt_stack_out), 32'(e_sp));
        chk({nm, ".idisable"}, 32'(interrupt_disable), 32'(e_p[2]));
        chk({nm, ".busy_end"}, 32'(interrupt_busy), 32'd0);
        chk({nm, ".we_end"}, 32'(interrupt_write_en), 32'd0);
        n = wr_a.size() - base;
        chk({nm, ".nwrites"}, 32'(n), 32'(e_nwr));
        for (int i = 0; i < e_nwr && i < n; i++) begin
            chk({nm, ".wr_addr"}, 32'(wr_a[base + i]), 32'(e_wa[i]));
            chk({nm, ".wr_data"}, 32'(wr_d[base + i]), 32'(e_wd[i]));
        end
        @(negedge clk);
        chk({nm, ".pc_hold"}, 32'(interrupt_pc_out), 32'(e_pc));
        chk({nm, ".done_hold"}, 32'(interrupt_done), 32'd1);
    endtask

    task automatic nmi_edge();
        @(negedge clk); ppu_status = {1'b0, 7'($urandom)};
        @(negedge clk); ppu_status = {1'b1, 7'($urandom)};
        @(negedge clk);
        m_nmi = 1'b1;
    endtask

    task automatic pulse_soft_reset();
        @(negedge clk); soft_reset = 1'b1;
        @(negedge clk); soft_reset = 1'b0;
        m_rst = 1'b1;
    endtask

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  p;
        logic [7:0]  sp;
        bit          brk;
        bit          rti;
        bit          nmi;
        bit          srst;
        bit          poke;
        logic [15:0] poke_a;
        logic [7:0]  poke_d;
        logic [15:0] x_pc;
        logic [7:0]  x_p;
        logic [7:0]  x_sp;
        int          x_nwr;
    } vec_t;

    vec_t tbl[9];

    task automatic check_reset_values(input string nm);
        chk({nm, ".addr"}, 32'(interrupt_addr), 32'd0);
        chk({nm, ".data"}, 32'(interrupt_data_out), 32'd0);
        chk({nm, ".we"}, 32'(interrupt_write_en), 32'd0);
        chk({nm, ".done"}, 32'(interrupt_done), 32'd0);
        chk({nm, ".busy"}, 32'(interrupt_busy), 32'd0);
        chk({nm, ".pc"}, 32'(interrupt_pc_out), 32'd0);
        chk({nm, ".status"}, 32'(interrupt_status_out), 32'd0);
        chk({nm, ".stack"}, 32'(interrupt_stack_out), 32'hFF);
        chk({nm, ".idisable"}, 32'(interrupt_disable), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat0;
        int lat1;
        int nw;
        tbl[0] = '{16'h8003, 8'h24, 8'hFD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h8003, 8'h24, 8'hFD, 0};
        tbl[1] = '{16'h1234, 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'hC000, 8'h04, 8'hFC, 3};
        tbl[2] = '{16'h0000, 8'h00, 8'hFC, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h01FD, 8'hD3, 16'h1234, 8'hE3, 8'hFF, 0};
        tbl[3] = '{16'h4567, 8'h04, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h9000, 8'h04, 8'hFC, 3};
        tbl[4] = '{16'h4000, 8'h24, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h4000, 8'h24, 8'hFC, 0};
        tbl[5] = '{16'h0000, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 16'h8000, 8'h04, 8'hFD, 0};
        tbl[6] = '{16'h2000, 8'hC1, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 16'hC000, 8'hC5, 8'h7D, 3};
        tbl[7] = '{16'h3000, 8'h00, 8'h7D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 16'h9000, 8'h04, 8'h7A, 3};
        tbl[8] = '{16'h1111, 8'h81, 8'h10, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 16'h8000, 8'h85, 8'h0D, 0};

        mem[16'hFFFA] = 8'h00; mem[16'hFFFB] = 8'h90;
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80;
        mem[16'hFFFE] = 8'h00; mem[16'hFFFF] = 8'hC0;

        rst = 1'b0; halt = 1'b0; is_break = 1'b0; is_rti = 1'b0; soft_reset = 1'b0;
        interrupt_start = 1'b0; ppu_status = 8'h00;
        pc_next = '0; ie_status = '0; stack_ptr = '0;
        repeat (3) @(negedge clk);
        check_reset_values("reset_held");
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("reset_released");

        foreach (tbl[k]) begin
            if (tbl[k].poke) mem[tbl[k].poke_a] = tbl[k].poke_d;
            if (tbl[k].srst) pulse_soft_reset();
            if (tbl[k].nmi) nmi_edge();
            run_op($sformatf("vec%0d", k), tbl[k].pc, tbl[k].p, tbl[k].sp,
                   tbl[k].brk, tbl[k].rti, -1, 0, lat0);
            chk($sformatf("vec%0d.tbl_pc", k), 32'(interrupt_pc_out), 32'(tbl[k].x_pc));
            chk($sformatf("vec%0d.tbl_status", k), 32'(interrupt_status_out), 32'(tbl[k].x_p));
            chk($sformatf("vec%0d.tbl_stack", k), 32'(interrupt_stack_out), 32'(tbl[k].x_sp));
            chk($sformatf("vec%0d.tbl_nwr", k), 32'(e_nwr), 32'(tbl[k].x_nwr));
            if (k == 0) chk("pass_latency", 32'(lat0 <= 2), 32'd1);
        end

        // halt mid-BRK: same result, delayed by exactly the halted cycles
        run_op("brk_ref", 16'hABCD, 8'h41, 8'h60, 1'b1, 1'b0, -1, 0, lat0);
        run_op("brk_halt", 16'hABCD, 8'h41, 8'h60, 1'b1, 1'b0, 2, 5, lat1);
        chk("halt_delay", 32'(lat1), 32'(lat0 + 5));
        run_op("rti_halt", 16'h0000, 8'h00, 8'h5D, 1'b0, 1'b1, 4, 3, lat1);

        // reset in the middle of a BRK push sequence
        @(negedge clk); ppu_status = 8'h00;
        @(negedge clk);
        pc_next = 16'h5555; ie_status = 8'h00; stack_ptr = 8'hF0;
        is_break = 1'b1; interrupt_start = 1'b1;
        @(negedge clk); interrupt_start = 1'b0; is_break = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_reset_values("midbrk_reset");
        nw = wr_a.size();
        repeat (3) @(negedge clk);
        chk("midbrk_no_writes", 32'(wr_a.size() - nw), 32'd0);
        rst = 1'b1;
        m_nmi = 1'b0; m_rst = 1'b0;
        run_op("after_reset", 16'h6001, 8'h20, 8'hF0, 1'b0, 1'b0, -1, 0, lat0);

        for (int i = 0; i < 16; i++) mem[16'hFFF0 + i] = 8'($urandom);
        for (int i = 0; i < 256; i++) mem[256 + i] = 8'($urandom);
        for (int it = 0; it < 40; it++) begin
            int r;
            int h_at;
            r = $urandom_range(0, 9);
            if ($urandom_range(0, 3) == 0) nmi_edge();
            else if ($urandom_range(0, 3) == 0) begin
                @(negedge clk); ppu_status = {1'b0, 7'($urandom)};
            end
            if ($urandom_range(0, 7) == 0) pulse_soft_reset();
            h_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 6) : -1;
            run_op($sformatf("rand%0d", it), 16'($urandom), 8'($urandom), 8'($urandom),
                   r < 3, r >= 3 && r < 5, h_at, $urandom_range(1, 4), lat0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
